// File: rtl/apb_cmd_master_if.sv
// Bundles the command/response channel and the APB4 requester bus of apb_cmd_master.
// The master modport is the requester's view; the slave modport is the opposite side.
interface apb_cmd_master_if #(
  parameter int APB_AW     = 32,
  parameter int APB_DW     = 32,
  parameter int SLAVES_QTY = 2
);
  localparam int PSTRB_W = APB_DW / 8;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_write;
  logic [APB_AW-1:0]     cmd_addr;
  logic [APB_DW-1:0]     cmd_wdata;
  logic [PSTRB_W-1:0]    cmd_wstrb;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [APB_DW-1:0]     rsp_rdata;
  logic [1:0]            rsp_err;

  logic [SLAVES_QTY-1:0] PSEL;
  logic                  PENABLE;
  logic                  PWRITE;
  logic [APB_AW-1:0]     PADDR;
  logic [APB_DW-1:0]     PWDATA;
  logic [PSTRB_W-1:0]    PSTRB;
  logic                  PREADY;
  logic [APB_DW-1:0]     PRDATA;
  logic                  PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    input  PREADY, PRDATA, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb, rsp_ready,
    output PREADY, PRDATA, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB
  );
endinterface

// File: rtl/apb_cmd_master.sv
// APB4 requester: one single-beat command at a time, decoded onto a static slave map,
// answered on a valid/ready response channel with OK/SLVERR/DECERR/TIMEOUT status.
module apb_cmd_master #(
  parameter int                          APB_AW      = 32,
  parameter int                          APB_DW      = 32,
  parameter int                          SLAVES_QTY  = 2,
  parameter logic [SLAVES_QTY*APB_AW-1:0] SLV_START  = {32'h0000_1000, 32'h0000_0000},
  parameter logic [SLAVES_QTY*APB_AW-1:0] SLV_END    = {32'h0000_1040, 32'h0000_1000},
  parameter int                          TIMEOUT_CYC = 256
) (
  input  logic             pclk,
  input  logic             prst,
  apb_cmd_master_if.master bus
);
  localparam int PSTRB_W = APB_DW / 8;
  localparam int CW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_OK  = 2'b00;
  localparam logic [1:0] ERR_SLV = 2'b01;
  localparam logic [1:0] ERR_DEC = 2'b10;
  localparam logic [1:0] ERR_TMO = 2'b11;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  state_t                state_reg;
  logic                  cmd_ready_reg;
  logic                  rsp_valid_reg;
  logic [APB_DW-1:0]     rsp_rdata_reg;
  logic [1:0]            rsp_err_reg;
  logic [SLAVES_QTY-1:0] psel_reg;
  logic                  penable_reg;
  logic                  pwrite_reg;
  logic [APB_AW-1:0]     paddr_reg;
  logic [APB_DW-1:0]     pwdata_reg;
  logic [PSTRB_W-1:0]    pstrb_reg;
  logic [CW-1:0]         tmo_cnt_reg;

  logic [SLAVES_QTY-1:0] hit_vec;
  logic [SLAVES_QTY-1:0] hit_sel;

  for (genvar gi = 0; gi < SLAVES_QTY; gi++) begin : g_decode
    assign hit_vec[gi] = (bus.cmd_addr >= SLV_START[gi*APB_AW +: APB_AW]) &&
                         (bus.cmd_addr <  SLV_END[gi*APB_AW +: APB_AW]);
  end

  // Isolate the lowest set bit so overlapping windows resolve to the lowest index.
  assign hit_sel = hit_vec & (~hit_vec + SLAVES_QTY'(1));

  always_ff @(posedge pclk) begin
    if (prst) begin
      state_reg     <= IDLE;
      cmd_ready_reg <= 1'b0;
      rsp_valid_reg <= 1'b0;
      rsp_rdata_reg <= '0;
      rsp_err_reg   <= ERR_OK;
      psel_reg      <= '0;
      penable_reg   <= 1'b0;
      pwrite_reg    <= 1'b0;
      paddr_reg     <= '0;
      pwdata_reg    <= '0;
      pstrb_reg     <= '0;
      tmo_cnt_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_ready_reg && bus.cmd_valid) begin
            cmd_ready_reg <= 1'b0;
            if (|hit_sel) begin
              state_reg  <= SETUP;
              psel_reg   <= hit_sel;
              pwrite_reg <= bus.cmd_write;
              paddr_reg  <= bus.cmd_addr;
              pwdata_reg <= bus.cmd_wdata;
              pstrb_reg  <= bus.cmd_write ? bus.cmd_wstrb : '0;
            end else begin
              state_reg     <= RESP;
              rsp_valid_reg <= 1'b1;
              rsp_rdata_reg <= '0;
              rsp_err_reg   <= ERR_DEC;
            end
          end else begin
            cmd_ready_reg <= 1'b1;
          end
        end

        SETUP: begin
          state_reg   <= ACCESS;
          penable_reg <= 1'b1;
          tmo_cnt_reg <= '0;
        end

        ACCESS: begin
          if (bus.PREADY || (tmo_cnt_reg == TMO_LAST)) begin
            state_reg     <= RESP;
            rsp_valid_reg <= 1'b1;
            psel_reg      <= '0;
            penable_reg   <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            pstrb_reg     <= '0;
            tmo_cnt_reg   <= '0;
            // A late PREADY on the final allowed cycle still completes normally.
            if (bus.PREADY) begin
              rsp_err_reg   <= bus.PSLVERR ? ERR_SLV : ERR_OK;
              rsp_rdata_reg <= (!pwrite_reg && !bus.PSLVERR) ? bus.PRDATA : '0;
            end else begin
              rsp_err_reg   <= ERR_TMO;
              rsp_rdata_reg <= '0;
            end
          end else begin
            tmo_cnt_reg <= tmo_cnt_reg + CW'(1);
          end
        end

        RESP: begin
          if (bus.rsp_ready) begin
            state_reg     <= IDLE;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= ERR_OK;
            cmd_ready_reg <= 1'b1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = cmd_ready_reg;
  assign bus.rsp_valid = rsp_valid_reg;
  assign bus.rsp_rdata = rsp_rdata_reg;
  assign bus.rsp_err   = rsp_err_reg;
  assign bus.PSEL      = psel_reg;
  assign bus.PENABLE   = penable_reg;
  assign bus.PWRITE    = pwrite_reg;
  assign bus.PADDR     = paddr_reg;
  assign bus.PWDATA    = pwdata_reg;
  assign bus.PSTRB     = pstrb_reg;
endmodule
